ir_fetch_sequencer: RTL and testbench

- Sequences nibble-serial instruction fetch into the 16-bit instruction register.
- Each instruction arrives from a 4-bit memory bus over four nibble reads, most-significant nibble first.
- Drives the one-hot IR load enable and the memory read handshake, and owns the program counter.
- Presents a valid/ack handshake to the decode/execute stage and accepts branch redirects (pc_load) and halt requests.

---
 rtl/ir_fetch_sequencer_if.sv | 24 ++
 rtl/ir_fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_ir_fetch_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_fetch_sequencer_if.sv
// Memory-bus and decode-handshake bundle for the nibble-serial IR fetch sequencer.
// master = sequencer side, slave = memory/decode side.
interface ir_fetch_sequencer_if #(
  parameter int PC_W = 12
) ();
  logic            mem_rd;
  logic [PC_W+1:0] mem_addr;
  logic            mem_ready;
  logic [3:0]      ir_en;
  logic            instr_valid;
  logic            instr_ack;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;

  modport master (
    output mem_rd, mem_addr, ir_en, instr_valid,
    input  mem_ready, instr_ack, pc_load, pc_target
  );

  modport slave (
    input  mem_rd, mem_addr, ir_en, instr_valid,
    output mem_ready, instr_ack, pc_load, pc_target
  );
endinterface

// File: rtl/ir_fetch_sequencer.sv
// Nibble-serial instruction fetch sequencer: four MSB-first nibble reads per 16-bit IR load.
// Optional fetch timeout with sticky bus_err enabled by defining FETCH_TIMEOUT_EN.
module ir_fetch_sequencer #(
  parameter int              PC_W        = 12,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  halt,
  ir_fetch_sequencer_if.master  bus,
  output logic [PC_W-1:0]       pc,
  output logic                  busy,
  output logic                  bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] nib_idx;

`ifdef FETCH_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  logic [WCW-1:0] wait_cnt;
  logic           err_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      nib_idx <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.pc_load) pc <= bus.pc_target;
          if (start) begin
            state   <= FETCH;
            nib_idx <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        FETCH: begin
          // A redirect flushes the partial word and outranks a ready nibble.
          if (bus.pc_load) begin
            pc      <= bus.pc_target;
            nib_idx <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else if (bus.mem_ready) begin
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (nib_idx == 2'd3) begin
              state   <= VALID;
              pc      <= pc + 1'b1;
              nib_idx <= '0;
            end else begin
              nib_idx <= nib_idx + 2'd1;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == WCW'(TIMEOUT_CYC - 1)) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        VALID: begin
          if (bus.pc_load) pc <= bus.pc_target;
          if (bus.instr_ack) begin
            nib_idx <= '0;
            state   <= halt ? IDLE : FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        default: begin
`ifdef FETCH_TIMEOUT_EN
          if (start) begin
            state <= IDLE;
            err_q <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

  assign bus.mem_rd      = (state == FETCH);
  assign bus.instr_valid = (state == VALID);
  assign bus.mem_addr    = {pc, nib_idx};
  assign busy            = (state != IDLE);

  // Mealy enable: the IR latches the nibble on the same edge mem_ready is sampled.
  assign bus.ir_en = (state == FETCH && bus.mem_ready && !bus.pc_load)
                     ? (4'b1000 >> nib_idx) : 4'b0000;

`ifdef FETCH_TIMEOUT_EN
  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
  wire unused_timeout = (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Scoreboarded bench for ir_fetch_sequencer: directed test-plan cases then randomized fetch/redirect/halt traffic.
module tb_ir_fetch_sequencer;
  localparam int PC_W = 12;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            halt = 1'b0;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            bus_err;

  ir_fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  ir_fetch_sequencer #(.PC_W(PC_W), .RESET_PC(12'h000), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
    .bus(bus), .pc(pc), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Nibble memory and the IR the sequencer loads through ir_en.
  logic [3:0]  mem [0:16383];
  logic [15:0] ir_tb = 16'h0;

  always @(posedge clk) begin
    if (bus.ir_en[3]) ir_tb[15:12] <= mem[bus.mem_addr];
    if (bus.ir_en[2]) ir_tb[11:8]  <= mem[bus.mem_addr];
    if (bus.ir_en[1]) ir_tb[7:4]   <= mem[bus.mem_addr];
    if (bus.ir_en[0]) ir_tb[3:0]   <= mem[bus.mem_addr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Scoreboard: one entry per fetch that should complete (word, pc after the fetch).
  typedef struct packed {
    logic [15:0]     word;
    logic [PC_W-1:0] pc_next;
  } exp_t;
  exp_t sb[$];
  logic [PC_W-1:0] mpc;

  function automatic logic [15:0] word_at(input logic [PC_W-1:0] p);
    return {mem[{p, 2'd0}], mem[{p, 2'd1}], mem[{p, 2'd2}], mem[{p, 2'd3}]};
  endfunction

  task automatic push_fetch(input logic [PC_W-1:0] p);
    logic [PC_W-1:0] nxt;
    nxt = p + 12'd1;
    sb.push_back({word_at(p), nxt});
    mpc = nxt;
  endtask

  // Memory responder: 0 always ready, 1 random (<=3 waits), 2 two waits per nibble, 3 never.
  int rdy_mode = 0;
  initial begin
    int wc;
    wc = 0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!bus.mem_rd) begin
        bus.mem_ready = 1'b0;
        wc = 0;
      end else begin
        case (rdy_mode)
          0: bus.mem_ready = 1'b1;
          1: if (wc >= 3 || $urandom_range(0, 2) != 0) begin bus.mem_ready = 1'b1; wc = 0; end
             else begin bus.mem_ready = 1'b0; wc++; end
          2: if (wc >= 2) begin bus.mem_ready = 1'b1; wc = 0; end
             else begin bus.mem_ready = 1'b0; wc++; end
          default: bus.mem_ready = 1'b0;
        endcase
      end
    end
  end

  // Monitor: each new instr_valid presents one completed fetch.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.instr_valid && !prev) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected_valid: got instr_valid required no pending fetch");
        end else begin
          e = sb.pop_front();
          chk("ir_word", 32'(ir_tb), 32'(e.word));
          chk("pc_after_fetch", 32'(pc), 32'(e.pc_next));
        end
      end
      prev = bus.instr_valid;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.instr_valid && n < 100) begin step(); n++; end
    if (!bus.instr_valid) begin
      n_chk++;
      $display("FAIL %s: instr_valid not seen within 100 cycles", name);
    end
  endtask

  task automatic ack_instr(input logic ld, input logic [PC_W-1:0] tgt, input logic hlt);
    bus.instr_ack = 1'b1; bus.pc_load = ld; bus.pc_target = tgt; halt = hlt;
    step();
    bus.instr_ack = 1'b0; bus.pc_load = 1'b0; halt = 1'b0;
  endtask

  initial begin
    logic [3:0]      one;
    logic [PC_W-1:0] p;
    logic [PC_W-1:0] tgt;
    logic            ld;
    logic            hlt;
    int              nib;
    int              stall;
    one = 4'b1000;
    bus.instr_ack = 1'b0; bus.pc_load = 1'b0; bus.pc_target = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom);
    mem[0] = 4'hA; mem[1] = 4'h3; mem[2] = 4'h5; mem[3] = 4'hC;

    // Reset state
    repeat (2) @(posedge clk);
    mid();
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_ir_en", 32'(bus.ir_en), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    step();
    reset_n = 1'b1;
    mpc = 12'h000;

    // Basic fetch, nibbles A,3,5,C
    push_fetch(12'h000);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("basic_ir_en", 32'(bus.ir_en), 32'(one >> k));
      chk("basic_addr", 32'(bus.mem_addr), 32'(k));
      step();
    end
    chk("basic_valid", 32'(bus.instr_valid), 32'd1);
    chk("basic_word", 32'(ir_tb), 32'h0000A35C);
    chk("basic_mem_rd_off", 32'(bus.mem_rd), 32'd0);
    ack_instr(1'b0, '0, 1'b1);
    chk("halt_busy", 32'(busy), 32'd0);

    // Two wait cycles before every nibble
    rdy_mode = 2;
    p = mpc;
    push_fetch(p);
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      mid();
      nib = c / 3;
      chk("wait_ir_en", 32'(bus.ir_en), (c % 3 == 2) ? 32'(one >> nib) : 32'd0);
      chk("wait_addr", 32'(bus.mem_addr), 32'(p) * 4 + 32'(nib));
      step();
    end
    chk("wait_valid_13", 32'(bus.instr_valid), 32'd1);
    ack_instr(1'b0, '0, 1'b1);
    rdy_mode = 0;

    // Ack stall then redirect on ack
    push_fetch(mpc);
    start = 1'b1; step(); start = 1'b0;
    wait_valid("stall_fetch");
    for (int s = 0; s < 4; s++) begin
      chk("stall_valid_hold", 32'(bus.instr_valid), 32'd1);
      if (s < 3) step();
    end
    push_fetch(12'h0F0);
    ack_instr(1'b1, 12'h0F0, 1'b0);
    chk("redirect_addr", 32'(bus.mem_addr), 32'h03C0);
    wait_valid("redirect_fetch");
    ack_instr(1'b0, '0, 1'b1);

    // Flush at nib_idx=2 with mem_ready high
    p = mpc;
    start = 1'b1; step(); start = 1'b0;
    push_fetch(12'd5);
    step(); step();
    bus.pc_load = 1'b1; bus.pc_target = 12'd5;
    mid();
    chk("flush_ir_en", 32'(bus.ir_en), 32'd0);
    chk("flush_addr_before", 32'(bus.mem_addr), 32'(p) * 4 + 32'd2);
    step();
    bus.pc_load = 1'b0;
    mid();
    chk("flush_restart_addr", 32'(bus.mem_addr), 32'd20);
    chk("flush_restart_ir_en", 32'(bus.ir_en), 32'h8);
    step();
    wait_valid("flush_fetch");
    ack_instr(1'b0, '0, 1'b1);

    // PC wrap, halt, restart from 0 (start beats halt in IDLE)
    bus.pc_load = 1'b1; bus.pc_target = 12'hFFF; step(); bus.pc_load = 1'b0;
    chk("idle_load_pc", 32'(pc), 32'hFFF);
    push_fetch(12'hFFF);
    start = 1'b1; step(); start = 1'b0;
    wait_valid("wrap_fetch");
    chk("wrap_pc", 32'(pc), 32'd0);
    ack_instr(1'b0, '0, 1'b1);
    chk("wrap_halt_busy", 32'(busy), 32'd0);
    chk("wrap_halt_pc", 32'(pc), 32'd0);
    push_fetch(12'h000);
    start = 1'b1; halt = 1'b1; step(); start = 1'b0; halt = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_addr", 32'(bus.mem_addr), 32'd0);
    wait_valid("restart_fetch");
    ack_instr(1'b0, '0, 1'b1);

    // 15 cycles without mem_ready
    rdy_mode = 3;
    p = mpc;
    start = 1'b1; step(); start = 1'b0;
    repeat (14) step();
    mid();
    chk("to_cycle15_err", 32'(bus_err), 32'd0);
    chk("to_cycle15_rd", 32'(bus.mem_rd), 32'd1);
    step();
    mid();
`ifdef FETCH_TIMEOUT_EN
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("to_busy", 32'(busy), 32'd1);
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("to_clear_err", 32'(bus_err), 32'd0);
    chk("to_clear_busy", 32'(busy), 32'd0);
    chk("to_pc_held", 32'(pc), 32'(p));
    rdy_mode = 0;
`else
    chk("to_no_err", 32'(bus_err), 32'd0);
    chk("to_still_rd", 32'(bus.mem_rd), 32'd1);
    chk("to_addr_held", 32'(bus.mem_addr), 32'(p) * 4);
    push_fetch(p);
    rdy_mode = 0;
    step();
    wait_valid("to_recover_fetch");
    ack_instr(1'b0, '0, 1'b1);
`endif

    // Reset in the middle of a fetch
    start = 1'b1; step(); start = 1'b0; step();
    reset_n = 1'b0; #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd", 32'(bus.mem_rd), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    step();
    reset_n = 1'b1;
    mpc = 12'h000;

    // Randomized traffic
    rdy_mode = 1;
    push_fetch(mpc);
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      wait_valid("rand_fetch");
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          tgt = 12'($urandom);
          bus.pc_load = 1'b1; bus.pc_target = tgt; mpc = tgt;
        end
        step();
        bus.pc_load = 1'b0;
      end
      ld  = ($urandom_range(0, 2) == 0);
      tgt = 12'($urandom);
      hlt = ($urandom_range(0, 5) == 0) || (n == 39);
      if (ld) mpc = tgt;
      if (!hlt) push_fetch(mpc);
      ack_instr(ld, tgt, hlt);
      if (hlt && n != 39) begin
        repeat ($urandom_range(0, 3)) step();
        ld  = $urandom_range(0, 1) == 1;
        tgt = 12'($urandom);
        if (ld) mpc = tgt;
        push_fetch(mpc);
        bus.pc_load = ld; bus.pc_target = tgt; start = 1'b1;
        step();
        bus.pc_load = 1'b0; start = 1'b0;
      end
    end
    repeat (3) step();
    chk("final_idle", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
